dht11_sensor_tx: RTL and testbench

//  Single-wire DHT11 responder (sensor side) for the 100 MHz fabric.
//  - Waits for a host start pulse on the open-drain data line.
//  - Replies with the 80 us low / 80 us high preamble.
//  - Then sends 40 bits, MSB first: hum_int, hum_dec, temp_int, temp_dec, checksum.
//  - Loop-back partner for the host-side DHT11 frame parser.
//  - Also the sensor model on the board-level bench.

---
 rtl/dht11_sensor_tx_if.sv | 48 ++++
 rtl/dht11_sensor_tx.sv | 211 +++++++++++++++++++++
 tb/tb_dht11_sensor_tx.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/dht11_sensor_tx_if.sv
`default_nettype none
// ============================================================================
//  Module      : dht11_sensor_tx_if
//  Description : Signal bundle between a DHT11 sensor-side responder and its
//                surroundings: the open-drain pad pair, the four sensor
//                measurement bytes and the frame status flags.
//  Signals     : line_in    - pad input, 1 when released (external pull-up)
//                drive_low  - 1 = pull pad low (open-drain enable)
//                hum_int/hum_dec/temp_int/temp_dec - measurement bytes
//                busy       - frame in progress
//                frame_done - one-cycle pulse at frame end
//  Modports    : slave  - the responder (dht11_sensor_tx)
//                master - the environment (pad model, byte source, monitor)
//  Revision    : 1.0 - initial release
// ============================================================================
interface dht11_sensor_tx_if;
  logic       line_in;
  logic       drive_low;
  logic [7:0] hum_int;
  logic [7:0] hum_dec;
  logic [7:0] temp_int;
  logic [7:0] temp_dec;
  logic       busy;
  logic       frame_done;

  modport slave (
    input  line_in,
    input  hum_int,
    input  hum_dec,
    input  temp_int,
    input  temp_dec,
    output drive_low,
    output busy,
    output frame_done
  );

  modport master (
    output line_in,
    output hum_int,
    output hum_dec,
    output temp_int,
    output temp_dec,
    input  drive_low,
    input  busy,
    input  frame_done
  );
endinterface
`default_nettype wire

// File: rtl/dht11_sensor_tx.sv
`default_nettype none
// ============================================================================
//  Module      : dht11_sensor_tx
//  Description : Single-wire DHT11 responder (sensor side). Waits for a host
//                start pulse on the open-drain data line, answers with the
//                low/high preamble and then shifts out 40 bits MSB first:
//                hum_int, hum_dec, temp_int, temp_dec, checksum.
//  Ports       : clk  - system clock (100 MHz nominal)
//                rst  - synchronous active-high reset
//                bus  - dht11_sensor_tx_if.slave (pad, sensor bytes, status)
//  Parameters  : START_MIN - minimum host low time accepted as a start
//                T_WAIT    - host release to response low
//                T_RESP    - response low time and response high time
//                T_BLOW    - per-bit low time (also final low)
//                T_H0/T_H1 - high time for a '0' / '1' bit
//                CW        - counter width, must hold START_MIN
//  Revision    : 1.0 - initial release
// ============================================================================
module dht11_sensor_tx #(
  parameter int START_MIN = 1800000,
  parameter int T_WAIT    = 3000,
  parameter int T_RESP    = 8000,
  parameter int T_BLOW    = 5400,
  parameter int T_H0      = 2400,
  parameter int T_H1      = 7000,
  parameter int CW        = 21
) (
  input  wire logic        clk,
  input  wire logic        rst,
  dht11_sensor_tx_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_HOST_LOW  = 3'd1,
    S_WAIT_REL  = 3'd2,
    S_RESP_LOW  = 3'd3,
    S_RESP_HIGH = 3'd4,
    S_BIT_LOW   = 3'd5,
    S_BIT_HIGH  = 3'd6,
    S_END_LOW   = 3'd7
  } state_t;

  localparam logic [CW-1:0] c_START_MIN = CW'(START_MIN);
  localparam logic [CW-1:0] c_WAIT_LAST = CW'(T_WAIT - 1);
  localparam logic [CW-1:0] c_RESP_LAST = CW'(T_RESP - 1);
  localparam logic [CW-1:0] c_BLOW_LAST = CW'(T_BLOW - 1);
  localparam logic [CW-1:0] c_H0_LAST   = CW'(T_H0 - 1);
  localparam logic [CW-1:0] c_H1_LAST   = CW'(T_H1 - 1);
  localparam logic [5:0]    c_MSB_IDX   = 6'd39;

  // Pad synchronizer; r_ls is the only view of the line the FSM uses.
  // r_ls_d keeps the previous synced value so IDLE can demand a fresh edge.
  logic r_sync1;
  logic r_ls;
  logic r_ls_d;

  state_t        r_state;
  state_t        w_next_state;
  logic [CW-1:0] r_cnt;
  logic [5:0]    r_bit_idx;
  logic [39:0]   r_frame;
  logic          r_drive_low;
  logic          r_busy;
  logic          r_frame_done;

  logic          w_fall;
  logic [9:0]    w_sum;
  logic [7:0]    w_chk;
  logic [CW-1:0] w_hold_last;
  logic          w_state_change;
  logic          w_start_ok;

  // A start is only taken from a falling edge seen in IDLE. While a frame is
  // running the line carries our own pulses; once it ends the synced value
  // may still be low, and that level must not be mistaken for a new start.
  assign w_fall = r_ls_d & ~r_ls;

  // Checksum wraps: 10-bit sum, low byte transmitted.
  assign w_sum = {2'b00, bus.hum_int} + {2'b00, bus.hum_dec}
               + {2'b00, bus.temp_int} + {2'b00, bus.temp_dec};
  assign w_chk = w_sum[7:0];

  assign w_hold_last    = r_frame[r_bit_idx] ? c_H1_LAST : c_H0_LAST;
  assign w_state_change = (w_next_state != r_state);
  assign w_start_ok     = (r_cnt >= c_START_MIN);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic. Only IDLE and HOST_LOW look at the line, so host
  // activity during a frame cannot disturb it.
  // --------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_fall) begin
          w_next_state = S_HOST_LOW;
        end
      end
      S_HOST_LOW: begin
        if (r_ls) begin
          w_next_state = w_start_ok ? S_WAIT_REL : S_IDLE;
        end
      end
      S_WAIT_REL: begin
        if (r_cnt == c_WAIT_LAST) begin
          w_next_state = S_RESP_LOW;
        end
      end
      S_RESP_LOW: begin
        if (r_cnt == c_RESP_LAST) begin
          w_next_state = S_RESP_HIGH;
        end
      end
      S_RESP_HIGH: begin
        if (r_cnt == c_RESP_LAST) begin
          w_next_state = S_BIT_LOW;
        end
      end
      S_BIT_LOW: begin
        if (r_cnt == c_BLOW_LAST) begin
          w_next_state = S_BIT_HIGH;
        end
      end
      S_BIT_HIGH: begin
        if (r_cnt == w_hold_last) begin
          w_next_state = (r_bit_idx == 6'd0) ? S_END_LOW : S_BIT_LOW;
        end
      end
      S_END_LOW: begin
        if (r_cnt == c_BLOW_LAST) begin
          w_next_state = S_IDLE;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath: synchronizer, cycle counter, frame capture, bit index, outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1      <= 1'b1;
      r_ls         <= 1'b1;
      r_ls_d       <= 1'b1;
      r_cnt        <= '0;
      r_bit_idx    <= '0;
      r_frame      <= '0;
      r_drive_low  <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_sync1 <= bus.line_in;
      r_ls    <= r_sync1;
      r_ls_d  <= r_ls;

      // Cycles spent in the current state. HOST_LOW saturates so an
      // arbitrarily long host pulse cannot wrap below the threshold.
      if (w_state_change || (r_state == S_IDLE)) begin
        r_cnt <= '0;
      end else if (r_state == S_HOST_LOW) begin
        if (!w_start_ok) begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end

      // Sensor bytes are frozen on entry to WAIT_REL.
      if ((r_state == S_HOST_LOW) && (w_next_state == S_WAIT_REL)) begin
        r_frame <= {bus.hum_int, bus.hum_dec, bus.temp_int, bus.temp_dec, w_chk};
        r_busy  <= 1'b1;
      end else if ((r_state == S_END_LOW) && (w_next_state == S_IDLE)) begin
        r_busy  <= 1'b0;
      end

      if ((r_state == S_RESP_HIGH) && (w_next_state == S_BIT_LOW)) begin
        r_bit_idx <= c_MSB_IDX;
      end else if ((r_state == S_BIT_HIGH) && (w_next_state == S_BIT_LOW)) begin
        r_bit_idx <= r_bit_idx - 6'd1;
      end

      r_frame_done <= (r_state == S_END_LOW) && (w_next_state == S_IDLE);

      // Pad enable follows the current state one cycle later; every low and
      // high phase therefore keeps its exact length on the wire.
      r_drive_low <= (r_state == S_RESP_LOW) || (r_state == S_BIT_LOW)
                  || (r_state == S_END_LOW);
    end
  end

  assign bus.drive_low  = r_drive_low;
  assign bus.busy       = r_busy;
  assign bus.frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_dht11_sensor_tx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_dht11_sensor_tx
//  Description : Self-checking bench for dht11_sensor_tx. Models the host
//                pad (wired-AND with the DUT pull-down), decodes the DUT's
//                pulse train and compares against hand-computed frames.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dht11_sensor_tx;

  localparam int P_START_MIN = 1800;
  localparam int P_T_WAIT    = 30;
  localparam int P_T_RESP    = 80;
  localparam int P_T_BLOW    = 54;
  localparam int P_T_H0      = 24;
  localparam int P_T_H1      = 70;

  logic clk = 1'b0;
  logic rst;
  logic host_low;

  always #5 clk = ~clk;

  dht11_sensor_tx_if bus ();

  // Open-drain pad: low if either side pulls.
  assign bus.line_in = ~(host_low | bus.drive_low);

  dht11_sensor_tx #(
    .START_MIN (P_START_MIN),
    .T_WAIT    (P_T_WAIT),
    .T_RESP    (P_T_RESP),
    .T_BLOW    (P_T_BLOW),
    .T_H0      (P_T_H0),
    .T_H1      (P_T_H1),
    .CW        (21)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int fd_count = 0;

  always @(negedge clk) begin
    if (bus.frame_done === 1'b1) fd_count++;
  end

  typedef struct {
    logic [7:0]  hi;
    logic [7:0]  hd;
    logic [7:0]  ti;
    logic [7:0]  td;
    logic [39:0] frame;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic set_bytes(input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] c, input logic [7:0] d);
    @(negedge clk);
    bus.hum_int  = a;
    bus.hum_dec  = b;
    bus.temp_int = c;
    bus.temp_dec = d;
  endtask

  task automatic host_start(input int n);
    @(negedge clk);
    host_low = 1'b1;
    repeat (n) @(negedge clk);
    host_low = 1'b0;
  endtask

  // Length in cycles of the current drive_low level, sampled on negedges.
  task automatic run_len(input logic lvl, output int len);
    len = 0;
    while (bus.drive_low === lvl && len < 20000) begin
      @(negedge clk);
      len++;
    end
  endtask

  // mode 0: plain; 1: change hum_int in BIT_LOW of bit 30;
  // mode 2: host collision (500 cycles low) starting at bit 35.
  task automatic capture_frame(input logic [39:0] exp, input int mode);
    int          w;
    int          len;
    int          lo_err;
    int          hi_err;
    int          fd0;
    logic [39:0] got;
    fd0 = fd_count;
    w = 0;
    while (bus.drive_low !== 1'b1 && w < 500) begin
      @(negedge clk);
      w++;
    end
    check("resp_start", {63'd0, bus.drive_low}, 64'd1);
    if (bus.drive_low !== 1'b1) return;
    check("busy_in_frame", {63'd0, bus.busy}, 64'd1);
    run_len(1'b1, len);
    check("resp_low_len", len, P_T_RESP);
    run_len(1'b0, len);
    check("resp_high_len", len, P_T_RESP);
    lo_err = 0;
    hi_err = 0;
    got    = '0;
    for (int i = 39; i >= 0; i--) begin
      if (mode == 1 && i == 30) bus.hum_int = 8'h55;
      if (mode == 2 && i == 35) begin
        fork
          begin
            host_low = 1'b1;
            repeat (500) @(negedge clk);
            host_low = 1'b0;
          end
        join_none
      end
      run_len(1'b1, len);
      if (len != P_T_BLOW) lo_err++;
      run_len(1'b0, len);
      got[i] = (len > (P_T_H0 + P_T_H1) / 2);
      if (len != (exp[i] ? P_T_H1 : P_T_H0)) hi_err++;
    end
    check("bit_low_errors", lo_err, 0);
    check("bit_high_errors", hi_err, 0);
    run_len(1'b1, len);
    check("end_low_len", len, P_T_BLOW);
    check("frame_value", {24'd0, got}, {24'd0, exp});
    repeat (5) @(negedge clk);
    check("frame_done_pulses", fd_count - fd0, 1);
    check("busy_after_frame", {63'd0, bus.busy}, 64'd0);
  endtask

  initial begin
    int w;
    int seen;
    int fd0;

    vecs[0] = '{8'h37, 8'h00, 8'h19, 8'h00, 40'h37_00_19_00_50};
    vecs[1] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 40'hFF_FF_FF_FF_FC};
    vecs[2] = '{8'h01, 8'h02, 8'h03, 8'h04, 40'h01_02_03_04_0A};
    vecs[3] = '{8'h80, 8'h80, 8'h80, 8'h80, 40'h80_80_80_80_00};
    vecs[4] = '{8'h12, 8'h34, 8'h56, 8'h78, 40'h12_34_56_78_14};

    host_low     = 1'b0;
    rst          = 1'b1;
    bus.hum_int  = '0;
    bus.hum_dec  = '0;
    bus.temp_int = '0;
    bus.temp_dec = '0;
    repeat (3) @(negedge clk);
    check("reset_drive_low", {63'd0, bus.drive_low}, 64'd0);
    check("reset_busy", {63'd0, bus.busy}, 64'd0);
    check("reset_frame_done", {63'd0, bus.frame_done}, 64'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Table of frames
    for (int v = 0; v < 5; v++) begin
      set_bytes(vecs[v].hi, vecs[v].hd, vecs[v].ti, vecs[v].td);
      host_start(2000);
      capture_frame(vecs[v].frame, 0);
      repeat (10) @(negedge clk);
    end

    // Short host pulse is rejected
    fd0 = fd_count;
    host_start(1000);
    seen = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (bus.drive_low !== 1'b0 || bus.busy !== 1'b0) seen++;
    end
    check("short_pulse_activity", seen, 0);
    check("short_pulse_frame_done", fd_count - fd0, 0);

    // Byte change mid-frame does not alter the frame
    set_bytes(8'h37, 8'h00, 8'h19, 8'h00);
    host_start(2000);
    capture_frame(40'h37_00_19_00_50, 1);
    repeat (10) @(negedge clk);

    // Host collision mid-frame does not alter timing or content
    set_bytes(8'h12, 8'h34, 8'h56, 8'h78);
    host_start(2000);
    capture_frame(40'h12_34_56_78_14, 2);
    repeat (10) @(negedge clk);

    // Reset during RESP_LOW, then a full frame
    set_bytes(8'h01, 8'h02, 8'h03, 8'h04);
    host_start(2000);
    w = 0;
    while (bus.drive_low !== 1'b1 && w < 500) begin
      @(negedge clk);
      w++;
    end
    check("rst_resp_low_reached", {63'd0, bus.drive_low}, 64'd1);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_drive_low", {63'd0, bus.drive_low}, 64'd0);
    check("rst_mid_busy", {63'd0, bus.busy}, 64'd0);
    rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (bus.drive_low !== 1'b0 || bus.busy !== 1'b0) seen++;
    end
    check("rst_stays_idle", seen, 0);
    host_start(2000);
    capture_frame(40'h01_02_03_04_0A, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
